// File: rtl/bsg_dff_reset_en_rr_ctrl.sv
// One shared reset/enable holding register fed by els_p requesters through a
// round-robin arbiter; acts as a 1-entry pipelined buffer with a valid/yumi output.
module bsg_dff_reset_en_rr_ctrl #(
    parameter int  width_p   = 32,
    parameter int  els_p     = 4,
    localparam int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [els_p-1:0]         v_i,
    input  logic [els_p*width_p-1:0] data_i,
    output logic [els_p-1:0]         yumi_o,
    output logic                     v_o,
    output logic [width_p-1:0]       data_o,
    output logic [lg_els_lp-1:0]     tag_o,
    input  logic                     yumi_i
);

    // Handshakes: requester k's word is consumed in the cycle yumi_o[k]=1
    // (yumi_o depends combinationally on v_i and yumi_i); downstream takes
    // data_o in the cycle yumi_i=1, which is only legal while v_o=1.

    logic                 r_v;
    logic [width_p-1:0]   r_data;
    logic [lg_els_lp-1:0] r_tag;
    logic [lg_els_lp-1:0] r_last;

    logic                 w_space;
    logic                 w_any_v;
    logic                 w_load;
    logic [lg_els_lp-1:0] w_grant;
    logic                 w_found;

    assign w_space = ~r_v | yumi_i;
    assign w_any_v = |v_i;
    assign w_load  = w_space & w_any_v & ~reset_i;

    // Search starts just after the last loaded requester and wraps modulo els_p.
    always_comb begin
        int idx;
        idx     = 0;
        w_grant = '0;
        w_found = 1'b0;
        for (int off = 1; off <= els_p; off++) begin
            idx = (int'(r_last) + off) % els_p;
            if (!w_found && v_i[idx]) begin
                w_found = 1'b1;
                w_grant = lg_els_lp'(idx);
            end
        end
    end

    always_comb begin
        yumi_o = '0;
        for (int k = 0; k < els_p; k++) begin
            yumi_o[k] = w_load && (w_grant == lg_els_lp'(k));
        end
    end

    // Priority pointer only moves on an actual load, so a stalled grant keeps its turn.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_v    <= 1'b0;
            r_data <= '0;
            r_tag  <= '0;
            r_last <= lg_els_lp'(els_p - 1);
        end else if (w_load) begin
            r_v    <= 1'b1;
            r_data <= data_i[w_grant*width_p +: width_p];
            r_tag  <= w_grant;
            r_last <= w_grant;
        end else if (yumi_i) begin
            r_v    <= 1'b0;
        end
    end

    assign v_o    = r_v;
    assign data_o = r_data;
    assign tag_o  = r_tag;

    a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> r_v);

endmodule

// File: tb/tb_bsg_dff_reset_en_rr_ctrl.sv
// Directed bench for bsg_dff_reset_en_rr_ctrl: reset, single load, round-robin
// streaming, backpressure, wrap/skip and reset while full.
module tb_bsg_dff_reset_en_rr_ctrl;

    localparam int W = 32;
    localparam int N = 4;

    logic           clk_i = 1'b0;
    logic           reset_i;
    logic [N-1:0]   v_i;
    logic [N*W-1:0] data_i;
    logic [N-1:0]   yumi_o;
    logic           v_o;
    logic [W-1:0]   data_o;
    logic [1:0]     tag_o;
    logic           yumi_i;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] d [N];

    bsg_dff_reset_en_rr_ctrl #(.width_p(W), .els_p(N)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (v_i),
        .data_i  (data_i),
        .yumi_o  (yumi_o),
        .v_o     (v_o),
        .data_o  (data_o),
        .tag_o   (tag_o),
        .yumi_i  (yumi_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic load_data();
        for (int k = 0; k < N; k++) data_i[k*W +: W] = d[k];
        #1;
    endtask

    initial begin
        d[0] = 32'h1111_0000;
        d[1] = 32'h2222_0001;
        d[2] = 32'h3333_0002;
        d[3] = 32'h4444_0003;
        reset_i = 1'b1;
        v_i     = 4'b1111;
        yumi_i  = 1'b0;
        data_i  = '0;
        load_data();

        // 1: reset held for two cycles with all requesters valid
        check("rst_yumi0", 32'(yumi_o), 32'h0);
        tick();
        check("rst_yumi1", 32'(yumi_o), 32'h0);
        tick();
        reset_i = 1'b0;
        v_i     = 4'b0000;
        #1;
        check("rst_v", 32'(v_o), 32'h0);
        check("rst_data", data_o, 32'h0);
        check("rst_tag", 32'(tag_o), 32'h0);

        // 2: single requester 2
        d[2] = 32'hDEAD_BEEF;
        v_i  = 4'b0100;
        load_data();
        check("single_yumi", 32'(yumi_o), 32'h4);
        tick();
        check("single_v", 32'(v_o), 32'h1);
        check("single_data", data_o, 32'hDEAD_BEEF);
        check("single_tag", 32'(tag_o), 32'h2);
        check("single_full_yumi", 32'(yumi_o), 32'h0);
        v_i    = 4'b0000;
        yumi_i = 1'b1;
        #1;
        check("drain_yumi", 32'(yumi_o), 32'h0);
        tick();
        yumi_i = 1'b0;
        #1;
        check("drain_v", 32'(v_o), 32'h0);
        check("drain_stale_data", data_o, 32'hDEAD_BEEF);
        check("drain_stale_tag", 32'(tag_o), 32'h2);

        // 3: reset restores pointer, then stream with all valid
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        d[2] = 32'h3333_0002;
        v_i  = 4'b1111;
        load_data();
        for (int i = 0; i < 8; i++) begin
            yumi_i = v_o;
            #1;
            check("rr_yumi", 32'(yumi_o), 32'(1 << (i % N)));
            tick();
            check("rr_v", 32'(v_o), 32'h1);
            check("rr_tag", 32'(tag_o), 32'(i % N));
            check("rr_data", data_o, d[i % N]);
        end

        // 4: backpressure while holding requester 1
        yumi_i = 1'b1;
        tick();
        check("bp_pre_tag0", 32'(tag_o), 32'h0);
        tick();
        check("bp_pre_tag1", 32'(tag_o), 32'h1);
        yumi_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_yumi", 32'(yumi_o), 32'h0);
            tick();
            check("bp_tag", 32'(tag_o), 32'h1);
            check("bp_data", data_o, d[1]);
            check("bp_v", 32'(v_o), 32'h1);
        end
        yumi_i = 1'b1;
        #1;
        check("bp_release_yumi", 32'(yumi_o), 32'h4);
        tick();
        check("bp_release_tag", 32'(tag_o), 32'h2);

        // 5: get last grant to 3, then wrap and skip invalid requester 0
        tick();
        check("wrap_pre_tag", 32'(tag_o), 32'h3);
        v_i = 4'b1010;
        #1;
        check("wrap_yumi1", 32'(yumi_o), 32'h2);
        tick();
        check("wrap_tag1", 32'(tag_o), 32'h1);
        check("wrap_data1", data_o, d[1]);
        check("wrap_yumi3", 32'(yumi_o), 32'h8);
        tick();
        check("wrap_tag3", 32'(tag_o), 32'h3);
        check("wrap_data3", data_o, d[3]);

        // 6: reset while full with tag 2
        v_i = 4'b0100;
        tick();
        check("rf_pre_tag", 32'(tag_o), 32'h2);
        check("rf_pre_v", 32'(v_o), 32'h1);
        reset_i = 1'b1;
        v_i     = 4'b1111;
        yumi_i  = 1'b0;
        #1;
        check("rf_rst_yumi", 32'(yumi_o), 32'h0);
        tick();
        reset_i = 1'b0;
        v_i     = 4'b0110;
        #1;
        check("rf_v", 32'(v_o), 32'h0);
        check("rf_data", data_o, 32'h0);
        check("rf_tag", 32'(tag_o), 32'h0);
        check("rf_first_yumi", 32'(yumi_o), 32'h2);
        tick();
        check("rf_first_tag", 32'(tag_o), 32'h1);
        check("rf_first_data", data_o, d[1]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
